mkio_manch_rx: RTL

MKIO_MANCH_RX -- requirements
Module: mkio_manch_rx

---
 rtl/mkio_manch_rx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mkio_manch_rx.sv
// mkio_manch_rx -- MIL-STD-1553 style Manchester word receiver.
//
// Decodes one word from a differential bus pair (di1/di0): a 3-bit-time sync
// (6 half-bits), DATA_W Manchester data bits MSB first, then one parity bit.
// The line is sampled once per half-bit, in the middle of the half-bit period,
// counted from the first clock on which the line left the idle state.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   rx_en       receiver enable; low forces the receiver back to idle
//   di1, di0    asynchronous bus legs; (1,0) = H, (0,1) = L, else idle/invalid
//   word_valid  one-cycle pulse, a completed word is on the word_* outputs
//   word_sync   1 = command/status sync, 0 = data sync
//   word_data   decoded data bits, first received bit in the MSB
//   parity_err  received parity does not match ODD_PARITY
//   manch_err   at least one pair was not (H,L) or (L,H)
//   sync_err    one-cycle pulse, the sync pattern was rejected
//   busy        high while a word is being received
module mkio_manch_rx #(
  parameter int CLKS_PER_HALFBIT = 16,
  parameter int DATA_W           = 16,
  parameter bit ODD_PARITY       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              di1,
  input  logic              di0,
  output logic              word_valid,
  output logic              word_sync,
  output logic [DATA_W-1:0] word_data,
  output logic              parity_err,
  output logic              manch_err,
  output logic              sync_err,
  output logic              busy
);

  localparam int NUM_HB = 8 + 2 * DATA_W;
  localparam int CNT_W  = $clog2(CLKS_PER_HALFBIT);
  localparam int IDX_W  = $clog2(NUM_HB);

  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE     = CNT_W'(CLKS_PER_HALFBIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(CLKS_PER_HALFBIT - 1);
  localparam logic [IDX_W-1:0] IDX_SYNC_SPLIT = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_SYNC_LAST  = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_FIRST_DATA = IDX_W'(6);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_HB - 1);

  typedef enum logic {IDLE, RX} state_t;

  state_t            state;
  logic              d1_meta, d1_sync, d0_meta, d0_sync;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  hidx;
  logic              wrap;
  logic              wait_idle;
  logic              cmd_ok, dat_ok, sync_is_cmd;
  logic              first_h, first_l;
  logic [DATA_W-1:0] data_sr;
  logic              pair_err_acc;

  logic line_h, line_l, line_ok;
  logic expect_h, cmd_ok_next, dat_ok_next;
  logic pair_bit, pair_bad, par_calc;

  assign line_h  = d1_sync & ~d0_sync;
  assign line_l  = ~d1_sync & d0_sync;
  assign line_ok = line_h | line_l;

  // The sync check runs on two candidate patterns at once; each flag stays
  // set only while every sample so far matches its pattern.
  assign expect_h    = (hidx < IDX_SYNC_SPLIT);
  assign cmd_ok_next = cmd_ok & (expect_h ? line_h : line_l);
  assign dat_ok_next = dat_ok & (expect_h ? line_l : line_h);

  // Second half of a pair: (H,L) = 1, (L,H) = 0, anything else is an error
  // and decodes as 0.
  assign pair_bit = first_h & line_l;
  assign pair_bad = ~((first_h & line_l) | (first_l & line_h));
  assign par_calc = ((^{data_sr, pair_bit}) != ODD_PARITY);

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_meta <= 1'b0;
      d1_sync <= 1'b0;
      d0_meta <= 1'b0;
      d0_sync <= 1'b0;
    end else begin
      d1_meta <= di1;
      d1_sync <= d1_meta;
      d0_meta <= di0;
      d0_sync <= d0_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hidx         <= '0;
      wrap         <= 1'b0;
      wait_idle    <= 1'b0;
      cmd_ok       <= 1'b0;
      dat_ok       <= 1'b0;
      sync_is_cmd  <= 1'b0;
      first_h      <= 1'b0;
      first_l      <= 1'b0;
      data_sr      <= '0;
      pair_err_acc <= 1'b0;
      word_valid   <= 1'b0;
      word_sync    <= 1'b0;
      word_data    <= '0;
      parity_err   <= 1'b0;
      manch_err    <= 1'b0;
      sync_err     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      sync_err   <= 1'b0;
      case (state)
        IDLE: begin
          // After a rejected sync the bus must go quiet before we re-arm,
          // otherwise we would lock onto the middle of the bad word.
          if (wait_idle) begin
            if (!line_ok) wait_idle <= 1'b0;
          end else if (rx_en && line_ok) begin
            state        <= RX;
            busy         <= 1'b1;
            cnt          <= CNT_ONE;
            hidx         <= '0;
            cmd_ok       <= 1'b1;
            dat_ok       <= 1'b1;
            pair_err_acc <= 1'b0;
          end
        end

        RX: begin
          if (!rx_en) begin
            state <= IDLE;
            busy  <= 1'b0;
            wrap  <= 1'b0;
          end else if (wrap) begin
            // This clock is count 0 of a following word if the line is
            // still driven, exactly as a fresh start from IDLE would be.
            wrap <= 1'b0;
            if (line_ok) begin
              cnt          <= CNT_ONE;
              hidx         <= '0;
              cmd_ok       <= 1'b1;
              dat_ok       <= 1'b1;
              pair_err_acc <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (hidx == IDX_LAST) wrap <= 1'b1;
              else                  hidx <= hidx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end

            if (cnt == CNT_SAMPLE) begin
              if (hidx < IDX_FIRST_DATA) begin
                cmd_ok <= cmd_ok_next;
                dat_ok <= dat_ok_next;
                if (hidx == IDX_SYNC_LAST) begin
                  if (!cmd_ok_next && !dat_ok_next) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sync_err  <= 1'b1;
                    wait_idle <= 1'b1;
                  end else begin
                    sync_is_cmd <= cmd_ok_next;
                  end
                end
              end else if (!hidx[0]) begin
                first_h <= line_h;
                first_l <= line_l;
              end else begin
                data_sr      <= {data_sr[DATA_W-2:0], pair_bit};
                pair_err_acc <= pair_err_acc | pair_bad;
                // The final pair is the parity bit; data_sr then already
                // holds exactly the DATA_W data bits.
                if (hidx == IDX_LAST) begin
                  word_valid <= 1'b1;
                  word_sync  <= sync_is_cmd;
                  word_data  <= data_sr;
                  parity_err <= par_calc;
                  manch_err  <= pair_err_acc | pair_bad;
                end
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
